// File: rtl/sram_controller.sv
// sram_controller: multi-cycle 32-bit word back-end for the memory stage.
// Each word access is split into two 16-bit SRAM phases (low half, then high
// half), each held on the bus for PHASE_CYCLES clocks, followed by a single
// DONE cycle in which o_ready pulses high.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   i_rd_en, i_wr_en   word read / write request, held until o_ready
//   i_address          byte address (BASE_ADDR is subtracted)
//   i_write_data       store data
//   o_read_data        loaded word, held until the next read completes
//   o_ready            0 while an access is pending (pipeline freeze)
//   io_sram_dq         SRAM data bus, driven only during write phases
//   o_sram_addr        SRAM half-word address
//   o_sram_we_n        SRAM write enable (active low)
//   o_sram_oe_n, o_sram_ce_n, o_sram_ub_n, o_sram_lb_n  strobes, tied active
module sram_controller #(
  parameter int unsigned BASE_ADDR    = 1024,
  parameter int unsigned PHASE_CYCLES = 2,
  parameter int unsigned SRAM_ADDR_W  = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rd_en,
  input  logic                   i_wr_en,
  input  logic [31:0]            i_address,
  input  logic [31:0]            i_write_data,
  output logic [31:0]            o_read_data,
  output logic                   o_ready,
  inout  wire  [15:0]            io_sram_dq,
  output logic [SRAM_ADDR_W-1:0] o_sram_addr,
  output logic                   o_sram_we_n,
  output logic                   o_sram_oe_n,
  output logic                   o_sram_ce_n,
  output logic                   o_sram_ub_n,
  output logic                   o_sram_lb_n
);

  localparam int unsigned IdxW    = SRAM_ADDR_W - 1;
  localparam logic [3:0]  LastCnt = 4'(PHASE_CYCLES - 1);
  // With a one-cycle phase the only cycle is the hold cycle, so we_n never drops.
  localparam logic        WeLowOk = (LastCnt != 4'd0);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e             r_state;
  logic [3:0]         r_cnt;
  logic               r_is_write;
  logic [IdxW-1:0]    r_index;
  logic [31:0]        r_wdata;
  logic [31:0]        r_read_data;
  logic [IdxW:0]      r_sram_addr;
  logic               r_we_n;
  logic               r_dq_oe;
  logic [15:0]        r_dq_out;

  logic [IdxW-1:0]    w_index;
  logic               w_last;
  logic [3:0]         w_cnt_inc;

  // Word index = (address - BASE_ADDR)[SRAM_ADDR_W:2]; byte offset is dropped.
  assign w_index   = IdxW'((i_address - 32'(BASE_ADDR)) >> 2);
  assign w_last    = (r_cnt == LastCnt);
  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_we_n      <= 1'b1;
      r_dq_oe     <= 1'b0;
      r_dq_out    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // Write wins if both requests are (illegally) present together.
          if (i_rd_en || i_wr_en) begin
            r_state     <= StLow;
            r_cnt       <= '0;
            r_is_write  <= i_wr_en;
            r_index     <= w_index;
            r_wdata     <= i_write_data;
            r_sram_addr <= {w_index, 1'b0};
            r_dq_out    <= i_write_data[15:0];
            r_dq_oe     <= i_wr_en;
            r_we_n      <= ~(i_wr_en && WeLowOk);
          end
        end
        StLow, StHigh: begin
          if (w_last) begin
            if (!r_is_write) begin
              if (r_state == StLow) r_read_data[15:0]  <= io_sram_dq;
              else                  r_read_data[31:16] <= io_sram_dq;
            end
            r_cnt <= '0;
            if (r_state == StLow) begin
              r_state     <= StHigh;
              r_sram_addr <= {r_index, 1'b1};
              r_dq_out    <= r_wdata[31:16];
              r_we_n      <= ~(r_is_write && WeLowOk);
            end else begin
              r_state <= StDone;
              r_we_n  <= 1'b1;
              r_dq_oe <= 1'b0;
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            // we_n rises for the final cycle of the phase to give data hold time.
            r_we_n <= ~(r_is_write && (w_cnt_inc != LastCnt));
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready     = ((r_state == StIdle) && !i_rd_en && !i_wr_en) || (r_state == StDone);
  assign o_read_data = r_read_data;
  assign o_sram_addr = r_sram_addr;
  assign o_sram_we_n = r_we_n;
  assign io_sram_dq  = r_dq_oe ? r_dq_out : 16'hzzzz;

  // Chip permanently selected, both byte lanes and output enable always active.
  assign o_sram_oe_n = 1'b0;
  assign o_sram_ce_n = 1'b0;
  assign o_sram_ub_n = 1'b0;
  assign o_sram_lb_n = 1'b0;

endmodule
